mem_port_arbiter: RTL and testbench

- Shares the single external memory port between three requesters: instruction-fetch line fill (IF), data-cache read fill (DR) and retire-time store write (WR).
- Sequences each transaction through a request/accept/complete handshake.
- Drives per-requester busy/done strobes, which feed the pipeline stall logic.
- Handles fetch squash on flush and prevents fetch starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter_priority.sv | 30 +++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: requester/owner encoding,
// transaction FSM states and the latched memory request.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_C       = 32;
  localparam int unsigned LINE_W_C       = 128;
  localparam int unsigned STARVE_LIMIT_C = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DR   = 2'd2,
    OWN_WR   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W_C-1:0] addr;
    logic [LINE_W_C-1:0] wdata;
    logic                we;
  } mem_req_t;

  // Fill data is only captured for the two read requesters.
  function automatic logic is_read(input owner_e own);
    return (own == OWN_IF) || (own == OWN_DR);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle: request/accept/complete handshake plus data.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_C,
  parameter int unsigned LINE_W = LINE_W_C
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_valid;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_valid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Fixed-priority requester selector (DR > WR > IF) with a starvation
// override that lets a waiting fetch jump the queue.
module mem_port_priority
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   dr_req,
  input  logic   wr_req,
  input  logic   flushing,
  input  logic   starve_hit,
  output owner_e grant
);

  // Fetch is never eligible during a flush, even when starved.
  always_comb begin
    grant = OWN_NONE;
    if (starve_hit && if_req && !flushing) begin
      grant = OWN_IF;
    end else if (dr_req) begin
      grant = OWN_DR;
    end else if (wr_req) begin
      grant = OWN_WR;
    end else if (if_req && !flushing) begin
      grant = OWN_IF;
    end else begin
      grant = OWN_NONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch fill, data read fill and
// store write; sequences each transaction and reports busy/done per requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_C,
  parameter int unsigned LINE_W       = LINE_W_C,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_C
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dr_req,
  input  logic [ADDR_W-1:0] dr_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              flushing,
  output logic              if_busy,
  output logic              dr_busy,
  output logic              wr_busy,
  output logic              if_done,
  output logic              dr_done,
  output logic              wr_done,
  output logic [LINE_W-1:0] rdata,
  mem_port_arbiter_if.master mem,
  output logic [1:0]        owner
);

  localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state_r;
  state_e            state_s;
  owner_e            owner_r;
  owner_e            grant_s;
  mem_req_t          req_r;
  mem_req_t          grant_req_s;
  logic              mem_req_r;
  logic [LINE_W-1:0] rdata_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              squash_r;
  logic              if_done_r;
  logic              dr_done_r;
  logic              wr_done_r;
  logic              starve_hit_s;
  logic              fire_s;
  logic              in_flight_s;
  logic              capture_s;
  logic              squash_set_s;
  logic              if_busy_s;
  logic              dr_busy_s;
  logic              wr_busy_s;

  assign starve_hit_s = (starve_cnt_r == CNT_MAX);
  assign fire_s       = (state_r == ST_IDLE) && (grant_s != OWN_NONE);
  assign in_flight_s  = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
  assign squash_set_s = flushing && (owner_r == OWN_IF) && in_flight_s;
  assign capture_s    = is_read(owner_r) && mem.mem_valid &&
                        ((state_r == ST_WAIT) || ((state_r == ST_ISSUE) && mem.mem_ready));

  mem_port_priority u_priority (
    .if_req     (if_req),
    .dr_req     (dr_req),
    .wr_req     (wr_req),
    .flushing   (flushing),
    .starve_hit (starve_hit_s),
    .grant      (grant_s)
  );

  // Request fields of whichever requester wins this cycle.
  always_comb begin
    grant_req_s = '0;
    case (grant_s)
      OWN_IF: grant_req_s.addr = if_addr;
      OWN_DR: grant_req_s.addr = dr_addr;
      OWN_WR: begin
        grant_req_s.addr  = wr_addr;
        grant_req_s.wdata = wr_data;
        grant_req_s.we    = 1'b1;
      end
      default: grant_req_s = '0;
    endcase
  end

  // Transaction FSM next state; ready+valid together in ISSUE skips WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != OWN_NONE) state_s = ST_ISSUE;
        else                     state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (mem.mem_ready && mem.mem_valid) state_s = ST_DONE;
        else if (mem.mem_ready)             state_s = ST_WAIT;
        else                                state_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (mem.mem_valid) state_s = ST_DONE;
        else               state_s = ST_WAIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Grant latch; the latched request drives the bus only while in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r   <= OWN_NONE;
      req_r     <= '0;
      mem_req_r <= 1'b0;
    end else begin
      mem_req_r <= (state_s == ST_ISSUE);
      if (fire_s) begin
        owner_r <= grant_s;
        req_r   <= grant_req_s;
      end else begin
        if (state_r == ST_DONE) owner_r <= OWN_NONE;
        if (state_s != ST_ISSUE) req_r <= '0;
      end
    end
  end

  // Fill data capture; a store completion leaves rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rdata_r <= '0;
    else if (capture_s) rdata_r <= mem.mem_rdata;
    else                rdata_r <= rdata_r;
  end

  // Completion strobes, high only in the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done_r <= 1'b0;
      dr_done_r <= 1'b0;
      wr_done_r <= 1'b0;
    end else begin
      if_done_r <= (state_s == ST_DONE) && (owner_r == OWN_IF) && !squash_r && !flushing;
      dr_done_r <= (state_s == ST_DONE) && (owner_r == OWN_DR);
      wr_done_r <= (state_s == ST_DONE) && (owner_r == OWN_WR);
    end
  end

  // A flushed fetch still finishes on the bus but never reports done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  squash_r <= 1'b0;
    else if (state_r == ST_DONE) squash_r <= 1'b0;
    else if (squash_set_s)       squash_r <= 1'b1;
    else                         squash_r <= squash_r;
  end

  // Counts data-side wins over a waiting fetch, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              starve_cnt_r <= '0;
    else if (!if_req)                        starve_cnt_r <= '0;
    else if (fire_s && (grant_s == OWN_IF))  starve_cnt_r <= '0;
    else if (fire_s && !starve_hit_s)        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    else                                     starve_cnt_r <= starve_cnt_r;
  end

  // Busy is pending-or-in-flight, dropping in DONE so the stall releases early.
  always_comb begin
    if_busy_s = (if_req && (owner_r != OWN_IF)) || ((owner_r == OWN_IF) && in_flight_s);
    dr_busy_s = (dr_req && (owner_r != OWN_DR)) || ((owner_r == OWN_DR) && in_flight_s);
    wr_busy_s = (wr_req && (owner_r != OWN_WR)) || ((owner_r == OWN_WR) && in_flight_s);
  end

  assign if_busy = reset && if_busy_s && !squash_r;
  assign dr_busy = reset && dr_busy_s;
  assign wr_busy = reset && wr_busy_s;

  assign if_done = if_done_r;
  assign dr_done = dr_done_r;
  assign wr_done = wr_done_r;
  assign rdata   = rdata_r;
  assign owner   = owner_r;

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = req_r.we;
  assign mem.mem_addr  = req_r.addr;
  assign mem.mem_wdata = req_r.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester traffic, a
// behavioural memory, and a monitor that checks bus requests and completions.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req, dr_req, wr_req, flushing;
  logic [AW-1:0] if_addr, dr_addr, wr_addr;
  logic [LW-1:0] wr_data;
  logic          if_busy, dr_busy, wr_busy, if_done, dr_done, wr_done;
  logic [LW-1:0] rdata;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) mem_if ();

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dr_req(dr_req), .dr_addr(dr_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .flushing(flushing),
    .if_busy(if_busy), .dr_busy(dr_busy), .wr_busy(wr_busy),
    .if_done(if_done), .dr_done(dr_done), .wr_done(wr_done),
    .rdata(rdata), .mem(mem_if), .owner(owner)
  );

  typedef struct {logic [1:0] owner; bit chk; logic [LW-1:0] rdata;} done_exp_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [LW-1:0] wdata;} bus_exp_t;
  typedef struct {logic [AW-1:0] addr; logic [LW-1:0] data;} wr_item_t;

  done_exp_t     exp_done[$];
  bus_exp_t      exp_bus[$];
  logic [AW-1:0] if_q[$];
  logic [AW-1:0] dr_q[$];
  wr_item_t      wr_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_lat = 3;
  bit combo = 1'b0;
  bit if_withdraw = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return {16{8'hAA}};
    else                    return {4{a}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_read(input logic [1:0] own, input logic [AW-1:0] a);
    exp_bus.push_back('{1'b0, a, {LW{1'b0}}});
    exp_done.push_back('{own, 1'b1, mem_data(a)});
  endtask

  task automatic exp_write(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [LW-1:0] keep);
    exp_bus.push_back('{1'b1, a, d});
    exp_done.push_back('{2'd3, 1'b1, keep});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_done.size() != 0 || exp_bus.size() != 0 || if_q.size() != 0 ||
            dr_q.size() != 0 || wr_q.size() != 0 || if_req || dr_req || wr_req ||
            owner != 2'd0 || mem_if.mem_req) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, LW'(n < 400), LW'(1'b1));
    repeat (2) @(negedge clk);
  endtask

  // Waits (bounded) until the given owner is in WAIT; returns at posedge+1.
  task automatic wait_in_wait(input string name, input logic [1:0] own);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(owner == own && !mem_if.mem_req) && n < 100);
    check({name, "_reach_wait"}, LW'(n < 100), LW'(1'b1));
  endtask

  // Behavioural memory: accepts on the first ISSUE cycle, completes later.
  initial begin
    int mphase = 0;
    int mcnt = 0;
    logic [AW-1:0] maddr = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_valid = 1'b0;
    mem_if.mem_rdata = {16{8'h55}};
    forever begin
      @(posedge clk); #1;
      mem_if.mem_ready = 1'b0;
      mem_if.mem_valid = 1'b0;
      mem_if.mem_rdata = {16{8'h55}};
      if (!reset) begin
        mphase = 0;
      end else if (mphase == 0) begin
        if (mem_if.mem_req) begin
          maddr = mem_if.mem_addr;
          mem_if.mem_ready = 1'b1;
          if (combo) begin
            mem_if.mem_valid = 1'b1;
            mem_if.mem_rdata = mem_data(maddr);
          end else begin
            mcnt = valid_lat;
            mphase = 1;
          end
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          mem_if.mem_valid = 1'b1;
          mem_if.mem_rdata = mem_data(maddr);
          mphase = 0;
        end
      end
    end
  end

  // Requesters: raise from their queue, hold until done (or fetch withdrawal).
  initial begin
    if_req = 1'b0; dr_req = 1'b0; wr_req = 1'b0;
    if_addr = '0; dr_addr = '0; wr_addr = '0; wr_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if_req = 1'b0; dr_req = 1'b0; wr_req = 1'b0;
      end else begin
        if (if_req && (if_done || if_withdraw)) begin
          if_req = 1'b0;
          if_withdraw = 1'b0;
        end else if (!if_req && if_q.size() > 0) begin
          if_addr = if_q.pop_front();
          if_req = 1'b1;
        end
        if (dr_req && dr_done) dr_req = 1'b0;
        else if (!dr_req && dr_q.size() > 0) begin
          dr_addr = dr_q.pop_front();
          dr_req = 1'b1;
        end
        if (wr_req && wr_done) wr_req = 1'b0;
        else if (!wr_req && wr_q.size() > 0) begin
          wr_item_t w;
          w = wr_q.pop_front();
          wr_addr = w.addr;
          wr_data = w.data;
          wr_req = 1'b1;
        end
      end
    end
  end

  // Monitor: compares bus requests and completions against the scoreboard.
  initial begin
    int valid_cyc = -10;
    int last_done_cyc = -100;
    logic prev_mem_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_if.mem_req && !prev_mem_req)
          check("grant_gap", LW'((cyc - last_done_cyc) >= 2), LW'(1'b1));
        if (mem_if.mem_req && mem_if.mem_ready) begin
          if (exp_bus.size() == 0) begin
            check("bus_unexpected", LW'(mem_if.mem_addr), LW'(1'b0));
          end else begin
            bus_exp_t b;
            b = exp_bus.pop_front();
            check("bus_we", LW'(mem_if.mem_we), LW'(b.we));
            check("bus_addr", LW'(mem_if.mem_addr), LW'(b.addr));
            check("bus_wdata", mem_if.mem_wdata, b.wdata);
          end
        end
        if (mem_if.mem_valid) valid_cyc = cyc;
        if (if_done || dr_done || wr_done) begin
          logic [1:0] code;
          code = if_done ? 2'd1 : (dr_done ? 2'd2 : 2'd3);
          check("done_onehot", LW'($countones({if_done, dr_done, wr_done})), LW'(1));
          if (exp_done.size() == 0) begin
            check("done_unexpected", LW'(code), LW'(0));
          end else begin
            done_exp_t e;
            e = exp_done.pop_front();
            check("done_who", LW'(code), LW'(e.owner));
            check("owner_at_done", LW'(owner), LW'(e.owner));
            if (e.chk) check("rdata", rdata, e.rdata);
            check("done_latency", LW'(cyc - valid_cyc), LW'(1));
          end
          last_done_cyc = cyc;
        end
      end
      prev_mem_req = mem_if.mem_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flushing = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_owner", LW'(owner), LW'(0));
    check("rst_flags", LW'({mem_if.mem_req, mem_if.mem_we, if_busy, dr_busy, wr_busy,
                            if_done, dr_done, wr_done}), LW'(0));
    check("rst_rdata", rdata, LW'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single data read
    exp_read(2'd2, 32'h0000_0100);
    dr_q.push_back(32'h0000_0100);
    wait_drain("single_dr");
    check("single_owner_idle", LW'(owner), LW'(0));
    check("single_rdata_hold", rdata, {16{8'hAA}});

    // Three-way contention
    exp_read(2'd2, 32'h0000_0200);
    exp_write(32'h0000_0300, {4{32'h1111_2222}}, mem_data(32'h0000_0200));
    exp_read(2'd1, 32'h0000_0400);
    dr_q.push_back(32'h0000_0200);
    wr_q.push_back('{32'h0000_0300, {4{32'h1111_2222}}});
    if_q.push_back(32'h0000_0400);
    wait_drain("contention");

    // Fetch starvation: four DR wins, then IF despite DR pending
    for (int i = 0; i < 4; i++) exp_read(2'd2, 32'h0000_0600 + 32'(i * 16));
    exp_read(2'd1, 32'h0000_0500);
    exp_read(2'd2, 32'h0000_0640);
    exp_write(32'h0000_0700, {4{32'hCAFE_F00D}}, mem_data(32'h0000_0640));
    if_q.push_back(32'h0000_0500);
    for (int i = 0; i < 5; i++) dr_q.push_back(32'h0000_0600 + 32'(i * 16));
    wr_q.push_back('{32'h0000_0700, {4{32'hCAFE_F00D}}});
    wait_drain("starve");

    // Fetch squashed by a flush while waiting on memory
    exp_bus.push_back('{1'b0, 32'h0000_0800, {LW{1'b0}}});
    if_q.push_back(32'h0000_0800);
    wait_in_wait("squash", 2'd1);
    flushing = 1'b1;
    if_withdraw = 1'b1;
    @(posedge clk); #1;
    check("sq_owner_inflight", LW'(owner), LW'(1));
    check("sq_if_busy", LW'(if_busy), LW'(0));
    flushing = 1'b0;
    wait_drain("squash");
    check("sq_owner_idle", LW'(owner), LW'(0));
    exp_read(2'd2, 32'h0000_0900);
    dr_q.push_back(32'h0000_0900);
    wait_drain("after_squash");

    // Store with accept and complete in the same cycle
    combo = 1'b1;
    exp_write(32'h0000_0A00, {4{32'hDEAD_BEEF}}, mem_data(32'h0000_0900));
    wr_q.push_back('{32'h0000_0A00, {4{32'hDEAD_BEEF}}});
    wait_drain("combo_wr");
    check("combo_rdata_hold", rdata, mem_data(32'h0000_0900));
    combo = 1'b0;

    // Asynchronous reset in the middle of a read
    valid_lat = 5;
    exp_bus.push_back('{1'b0, 32'h0000_0B00, {LW{1'b0}}});
    dr_q.push_back(32'h0000_0B00);
    wait_in_wait("reset", 2'd2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_owner", LW'(owner), LW'(0));
    check("arst_flags", LW'({mem_if.mem_req, mem_if.mem_we, if_busy, dr_busy, wr_busy,
                             if_done, dr_done, wr_done}), LW'(0));
    check("arst_rdata", rdata, LW'(0));
    check("arst_bus_accepted", LW'(exp_bus.size()), LW'(0));
    exp_done.delete();
    exp_bus.delete();
    dr_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    valid_lat = 3;
    exp_read(2'd2, 32'h0000_0C00);
    dr_q.push_back(32'h0000_0C00);
    wait_drain("post_reset");
    check("post_reset_rdata", rdata, mem_data(32'h0000_0C00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
